// File: rtl/proj3_pkg.sv
// Shared constants for the Project 3 multi-cycle CPU control path:
// opcode fields, sequencer state encoding, PC and write-back selects.
package proj3_pkg;

    localparam logic [3:0] OP1_ALUR  = 4'b0000;
    localparam logic [3:0] OP1_ALUI  = 4'b1000;
    localparam logic [3:0] OP1_CMPR  = 4'b0010;
    localparam logic [3:0] OP1_CMPI  = 4'b1010;
    localparam logic [3:0] OP1_LW    = 4'b1001;
    localparam logic [3:0] OP1_SW    = 4'b0101;
    localparam logic [3:0] OP1_BCOND = 4'b0110;
    localparam logic [3:0] OP1_JAL   = 4'b1011;

    localparam logic [3:0] OP2_ADD   = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] PC_PLUS   = 2'd0;
    localparam logic [1:0] PC_BRTARG = 2'd1;
    localparam logic [1:0] PC_ALUOUT = 2'd2;

    localparam logic [1:0] W_ALU     = 2'd0;
    localparam logic [1:0] W_MEM     = 2'd1;
    localparam logic [1:0] W_PCPLUS  = 2'd2;

    function automatic logic op1_legal(
        input logic [3:0] op
    );
        logic ok;
        ok = 1'b0;
        case (op)
            OP1_ALUR, OP1_ALUI,
            OP1_CMPR, OP1_CMPI,
            OP1_LW,   OP1_SW,
            OP1_BCOND, OP1_JAL: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_step_edge.sv
// step_edge: registers the synchronised step key (clk, lock, key)
// and emits a one-cycle pulse on its falling edge (pulse).
module step_edge (
    input  logic clk,
    input  logic lock,
    input  logic key,
    output logic pulse
);

    logic key_q;

    // Reset to released so a key held down through reset
    // does not count as a press.
    always_ff @(posedge clk or negedge lock) begin
        if (!lock) key_q <= 1'b1;
        else       key_q <= key;
    end

    assign pulse = key_q & ~key;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: Moore sequencer FETCH/DECODE/EXEC/MEM/WB for the CPU.
// In: clk, lock, op fields, cond_true, run, step_key. Out: strobes,
// selects, alufunc/aluimm, halted, sticky illegal, retired count.
module cpu_seq_ctrl
    import proj3_pkg::*;
#(
    parameter logic [31:0] STARTPC = 32'h40,
    parameter int          CNTBITS = 16
) (
    input  logic               clk,
    input  logic               lock,
    input  logic [3:0]         op1,
    input  logic [3:0]         rd_f,
    input  logic [3:0]         rt_f,
    input  logic [3:0]         op2_i,
    input  logic               cond_true,
    input  logic               run,
    input  logic               step_key,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               aluimm,
    output logic [4:0]         alufunc,
    output logic               wrmem,
    output logic               wrreg,
    output logic [1:0]         wsel,
    output logic               halted,
    output logic               illegal,
    output logic [CNTBITS-1:0] retired
);

    // STARTPC belongs to the PC register upstream; only its
    // word alignment is checked here.
    if (STARTPC[1:0] != 2'b00) begin : g_bad_startpc
        $error("STARTPC must be word aligned");
    end

    state_t       state, nxt;
    logic [3:0]   op1_q, rd_q, rt_q, op2_q;
    logic         illegal_q;
    logic [CNTBITS-1:0] retired_q;
    logic         step_pulse;
    logic         last;
    logic         set_ill;
    logic         in_ex;

    step_edge u_step (
        .clk   (clk),
        .lock  (lock),
        .key   (step_key),
        .pulse (step_pulse)
    );

    always_ff @(posedge clk or negedge lock) begin
        if (!lock) begin
            state     <= S_IDLE;
            op1_q     <= '0;
            rd_q      <= '0;
            rt_q      <= '0;
            op2_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state <= nxt;
            // IR is loaded at the end of FETCH, so its fields
            // are stable throughout DECODE.
            if (state == S_DECODE) begin
                op1_q <= op1;
                rd_q  <= rd_f;
                rt_q  <= rt_f;
                op2_q <= op2_i;
            end
            if (set_ill) illegal_q <= 1'b1;
            if (last)    retired_q <= retired_q + CNTBITS'(1);
        end
    end

    always_comb begin
        nxt     = state;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_PLUS;
        wrmem   = 1'b0;
        wrreg   = 1'b0;
        wsel    = W_ALU;
        halted  = 1'b0;
        last    = 1'b0;
        set_ill = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run || step_pulse) nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
                nxt   = S_DECODE;
            end
            S_DECODE: begin
                if (op1_legal(op1)) begin
                    nxt = S_EXEC;
                end else begin
                    nxt     = S_HALT;
                    set_ill = 1'b1;
                end
            end
            S_EXEC: begin
                unique case (op1_q)
                    OP1_BCOND: begin
                        pc_we  = cond_true;
                        pc_sel = PC_BRTARG;
                        last   = 1'b1;
                    end
                    OP1_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_ALUOUT;
                        nxt    = S_WB;
                    end
                    OP1_LW, OP1_SW: nxt = S_MEM;
                    default:        nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (op1_q == OP1_SW) begin
                    wrmem = 1'b1;
                    last  = 1'b1;
                end else begin
                    nxt = S_WB;
                end
            end
            S_WB: begin
                wrreg = 1'b1;
                last  = 1'b1;
                unique case (1'b1)
                    op1_q == OP1_LW:  wsel = W_MEM;
                    op1_q == OP1_JAL: wsel = W_PCPLUS;
                    default:          wsel = W_ALU;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: nxt = S_IDLE;
        endcase
        if (last) nxt = run ? S_FETCH : S_IDLE;
    end

    assign in_ex = (state == S_EXEC) ||
                   (state == S_MEM)  ||
                   (state == S_WB);

    always_comb begin
        alufunc = '0;
        aluimm  = 1'b0;
        if (in_ex) begin
            unique case (op1_q)
                OP1_ALUR: alufunc = {1'b0, op2_q};
                OP1_ALUI: begin
                    alufunc = {1'b0, rt_q};
                    aluimm  = 1'b1;
                end
                OP1_CMPR: alufunc = {1'b1, op2_q};
                OP1_CMPI: begin
                    alufunc = {1'b1, rt_q};
                    aluimm  = 1'b1;
                end
                OP1_BCOND: alufunc = {1'b1, rd_q};
                // LW, SW and JAL all form an address base+imm.
                default: begin
                    alufunc = {1'b0, OP2_ADD};
                    aluimm  = 1'b1;
                end
            endcase
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
